// File: rtl/gshare_btb2_ras_predictor_if.sv
// Fetch-side prediction and EX-side resolve signals of the gshare/BTB/RAS branch predictor.
interface gshare_btb2_ras_predictor_if #(
  parameter int PHT_W = 8,
  parameter int RAS_W = 3
);
  logic                 f_valid;
  logic [31:0]          f_pc;
  logic [6:0]           f_opcode;
  logic [4:0]           f_rd;
  logic [4:0]           f_rs1;
  logic                 pred_taken;
  logic [31:0]          pred_target;
  logic [PHT_W-1:0]     pred_pht_idx;
  logic [2*RAS_W:0]     pred_ras_ckpt;
  logic                 r_valid;
  logic [31:0]          r_pc;
  logic [6:0]           r_opcode;
  logic [PHT_W-1:0]     r_pht_idx;
  logic [2*RAS_W:0]     r_ras_ckpt;
  logic                 r_taken;
  logic [31:0]          r_target;
  logic                 r_mispredict;

  modport master (
    output f_valid, f_pc, f_opcode, f_rd, f_rs1,
    output r_valid, r_pc, r_opcode, r_pht_idx, r_ras_ckpt, r_taken, r_target, r_mispredict,
    input  pred_taken, pred_target, pred_pht_idx, pred_ras_ckpt
  );
  modport slave (
    input  f_valid, f_pc, f_opcode, f_rd, f_rs1,
    input  r_valid, r_pc, r_opcode, r_pht_idx, r_ras_ckpt, r_taken, r_target, r_mispredict,
    output pred_taken, pred_target, pred_pht_idx, pred_ras_ckpt
  );
endinterface

// File: rtl/gshare_btb2_ras_predictor.sv
// Fetch-stage predictor: gshare direction, 2-way LRU BTB, circular RAS with {ptr,count} checkpoints.
module gshare_btb2_ras_predictor #(
  parameter int         PHT_DEPTH = 256,
  parameter int         HIST_LEN  = 8,
  parameter int         BTB_SETS  = 16,
  parameter int         RAS_DEPTH = 8,
  parameter logic [1:0] PHT_INIT  = 2'b10
)(
  input logic clk,
  input logic reset,
  gshare_btb2_ras_predictor_if.slave bus
);
  localparam int PHT_W = $clog2(PHT_DEPTH);
  localparam int SET_W = $clog2(BTB_SETS);
  localparam int TAG_W = 30 - SET_W;
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic [HIST_LEN-1:0] ghr, ghr_next;
  logic [1:0]          pht     [PHT_DEPTH];
  logic [1:0]          btb_vld [BTB_SETS];
  logic [TAG_W-1:0]    btb_tag [BTB_SETS][2];
  logic [31:0]         btb_tgt [BTB_SETS][2];
  logic [BTB_SETS-1:0] lru;
  logic [31:0]         ras     [RAS_DEPTH];
  logic [RAS_W-1:0]    ras_ptr, nxt_ptr;
  logic [RAS_W:0]      ras_cnt, nxt_cnt;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // ---------------- fetch side ----------------
  logic f_br, f_jal, f_jalr, f_call, f_ret, f_callret, f_hit0, f_hit1, f_hit, taken;
  logic [SET_W-1:0] f_set;
  logic [TAG_W-1:0] f_tag;
  logic [PHT_W-1:0] f_idx;
  logic [31:0]      pc4, f_hit_tgt, target;

  assign f_br      = bus.f_opcode == OP_BR;
  assign f_jal     = bus.f_opcode == OP_JAL;
  assign f_jalr    = bus.f_opcode == OP_JALR;
  assign f_callret = f_jalr && is_link(bus.f_rd) && is_link(bus.f_rs1) && (bus.f_rs1 != bus.f_rd);
  assign f_call    = (f_jal || f_jalr) && is_link(bus.f_rd) && !f_callret;
  assign f_ret     = f_jalr && is_link(bus.f_rs1) && !is_link(bus.f_rd);

  assign f_set     = bus.f_pc[SET_W+1:2];
  assign f_tag     = bus.f_pc[31:SET_W+2];
  assign f_hit0    = btb_vld[f_set][0] && (btb_tag[f_set][0] == f_tag);
  assign f_hit1    = btb_vld[f_set][1] && (btb_tag[f_set][1] == f_tag);
  assign f_hit     = f_hit0 || f_hit1;
  assign f_hit_tgt = f_hit0 ? btb_tgt[f_set][0] : btb_tgt[f_set][1];
  assign f_idx     = bus.f_pc[PHT_W+1:2] ^ PHT_W'(ghr);
  assign pc4       = bus.f_pc + 32'd4;

  always_comb begin
    taken  = 1'b0;
    target = pc4;
    if ((f_ret || f_callret) && ras_cnt != '0) begin
      taken  = 1'b1;
      target = ras[ras_ptr];
    end else if (f_hit && (f_jal || f_jalr)) begin
      taken  = 1'b1;
      target = f_hit_tgt;
    end else if (f_hit && f_br && pht[f_idx][1]) begin
      taken  = 1'b1;
      target = f_hit_tgt;
    end
  end

  // RAS state after this instruction's own op; also the checkpoint sent down the pipe
  always_comb begin
    nxt_ptr = ras_ptr;
    nxt_cnt = ras_cnt;
    if (f_call) begin
      nxt_ptr = ras_ptr + 1'b1;
      if (ras_cnt != (RAS_W+1)'(RAS_DEPTH)) nxt_cnt = ras_cnt + 1'b1;
    end else if (f_ret && ras_cnt != '0) begin
      nxt_ptr = ras_ptr - 1'b1;
      nxt_cnt = ras_cnt - 1'b1;
    end
  end

  assign bus.pred_taken    = taken;
  assign bus.pred_target   = target;
  assign bus.pred_pht_idx  = f_idx;
  assign bus.pred_ras_ckpt = {nxt_ptr, nxt_cnt};

  // ---------------- resolve side ----------------
  logic             restore, r_br, r_cf, r_hit0, r_hit1, alloc_way, wr_way, btb_wr;
  logic [SET_W-1:0] r_set;
  logic [TAG_W-1:0] r_tag;
  logic [1:0]       pht_cur, pht_nxt;
  wire              unused_ok = &{1'b0, bus.r_pc[1:0]};

  assign restore   = bus.r_valid && bus.r_mispredict;
  assign r_br      = bus.r_opcode == OP_BR;
  assign r_cf      = r_br || bus.r_opcode == OP_JAL || bus.r_opcode == OP_JALR;
  assign r_set     = bus.r_pc[SET_W+1:2];
  assign r_tag     = bus.r_pc[31:SET_W+2];
  assign r_hit0    = btb_vld[r_set][0] && (btb_tag[r_set][0] == r_tag);
  assign r_hit1    = btb_vld[r_set][1] && (btb_tag[r_set][1] == r_tag);
  assign alloc_way = !btb_vld[r_set][0] ? 1'b0 : (!btb_vld[r_set][1] ? 1'b1 : lru[r_set]);
  assign wr_way    = r_hit0 ? 1'b0 : (r_hit1 ? 1'b1 : alloc_way);
  assign btb_wr    = bus.r_valid && r_cf && bus.r_taken;
  assign pht_cur   = pht[bus.r_pht_idx];

  always_comb begin
    pht_nxt = pht_cur;
    if (bus.r_taken && pht_cur != 2'b11) pht_nxt = pht_cur + 2'b01;
    else if (!bus.r_taken && pht_cur != 2'b00) pht_nxt = pht_cur - 2'b01;
  end

  if (HIST_LEN > 1) begin : g_hist
    assign ghr_next = {ghr[HIST_LEN-2:0], bus.r_taken};
  end else begin : g_hist1
    assign ghr_next = bus.r_taken;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr     <= '0;
      lru     <= '0;
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= PHT_INIT;
      for (int s = 0; s < BTB_SETS; s++) btb_vld[s] <= 2'b00;
    end else begin
      // a mispredict flushes the fetched instruction, so its RAS op is dropped
      if (restore) {ras_ptr, ras_cnt} <= bus.r_ras_ckpt;
      else if (bus.f_valid) begin
        ras_ptr <= nxt_ptr;
        ras_cnt <= nxt_cnt;
      end
      if (bus.r_valid && r_br) begin
        ghr               <= ghr_next;
        pht[bus.r_pht_idx] <= pht_nxt;
      end
      if (btb_wr) begin
        btb_vld[r_set][wr_way] <= 1'b1;
        lru[r_set]             <= ~wr_way;
      end
    end
  end

  // payload arrays carry no reset; validity lives in btb_vld / ras_cnt
  always_ff @(posedge clk) begin
    if (!reset && btb_wr) begin
      btb_tag[r_set][wr_way] <= r_tag;
      btb_tgt[r_set][wr_way] <= bus.r_target;
    end
    if (!reset && !restore && bus.f_valid) begin
      if (f_call) ras[nxt_ptr] <= pc4;
      else if (f_callret) ras[ras_ptr] <= pc4;
    end
  end
endmodule

// File: tb/tb_gshare_btb2_ras_predictor.sv
// Directed vector bench for gshare_btb2_ras_predictor: table of cycles plus hand-built corner sequences.
module tb_gshare_btb2_ras_predictor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, NOP = 7'b0010011;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] fpc;
    logic [6:0]  fop;
    logic [4:0]  frd, frs1;
    logic        rv;
    logic [31:0] rpc;
    logic [6:0]  rop;
    logic [7:0]  ridx;
    logic [6:0]  rck;
    logic        rtk;
    logic [31:0] rtgt;
    logic        rmis;
    logic        chk, chk_tgt;
    logic        etk;
    logic [31:0] etgt;
    logic [7:0]  eidx;
    logic [6:0]  eck;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  gshare_btb2_ras_predictor_if #(.PHT_W(8), .RAS_W(3)) ifc ();

  gshare_btb2_ras_predictor #(
    .PHT_DEPTH(256), .HIST_LEN(8), .BTB_SETS(16), .RAS_DEPTH(8), .PHT_INIT(2'b10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  function automatic logic [6:0] ck(input int p, input int c);
    return {3'(p), 4'(c)};
  endfunction

  function automatic vec_t fx(input logic fv, input logic [31:0] pc, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic etk,
                              input logic [31:0] etgt, input logic [7:0] eidx, input logic [6:0] eck);
    vec_t v;
    v = '{default: '0};
    v.fv = fv; v.fpc = pc; v.fop = op; v.frd = rd; v.frs1 = rs1;
    v.chk = 1'b1; v.chk_tgt = 1'b1;
    v.etk = etk; v.etgt = etgt; v.eidx = eidx; v.eck = eck;
    return v;
  endfunction

  function automatic vec_t rx(input vec_t vi, input logic [31:0] rpc, input logic [6:0] rop,
                              input logic [7:0] ridx, input logic rtk, input logic [31:0] rtgt,
                              input logic rmis, input logic [6:0] rck);
    vec_t v;
    v = vi;
    v.rv = 1'b1; v.rpc = rpc; v.rop = rop; v.ridx = ridx;
    v.rtk = rtk; v.rtgt = rtgt; v.rmis = rmis; v.rck = rck;
    return v;
  endfunction

  function automatic vec_t quiet(input logic [31:0] pc);
    vec_t v;
    v = fx(1'b0, pc, NOP, 5'd0, 5'd0, 1'b0, 32'd0, 8'd0, 7'd0);
    v.chk = 1'b0;
    return v;
  endfunction

  function automatic vec_t rstv();
    vec_t v;
    v = quiet(32'h0);
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    reset             = v.rst;
    ifc.f_valid       = v.fv;
    ifc.f_pc          = v.fpc;
    ifc.f_opcode      = v.fop;
    ifc.f_rd          = v.frd;
    ifc.f_rs1         = v.frs1;
    ifc.r_valid       = v.rv;
    ifc.r_pc          = v.rpc;
    ifc.r_opcode      = v.rop;
    ifc.r_pht_idx     = v.ridx;
    ifc.r_ras_ckpt    = v.rck;
    ifc.r_taken       = v.rtk;
    ifc.r_target      = v.rtgt;
    ifc.r_mispredict  = v.rmis;
    #1;
    if (v.chk) begin
      cmp({tag, " taken"}, 32'(ifc.pred_taken), 32'(v.etk));
      if (v.chk_tgt) cmp({tag, " target"}, ifc.pred_target, v.etgt);
      cmp({tag, " pht_idx"}, 32'(ifc.pred_pht_idx), 32'(v.eidx));
      cmp({tag, " ras_ckpt"}, 32'(ifc.pred_ras_ckpt), 32'(v.eck));
    end
  endtask

  vec_t tbl [13];

  initial begin
    // basic direction/BTB training, call/return, PHT saturation
    tbl[0]  = rstv();
    tbl[1]  = fx(0, 32'h500, NOP, 0, 0, 0, 32'h504, 8'h40, ck(0, 0));
    tbl[2]  = fx(1, 32'h100, BR, 0, 0, 0, 32'h104, 8'h40, ck(0, 0));
    tbl[3]  = rx(fx(0, 32'h104, NOP, 0, 0, 0, 32'h108, 8'h41, ck(0, 0)),
                 32'h100, BR, 8'h40, 1, 32'h80, 1, ck(0, 0));
    tbl[4]  = fx(1, 32'h100, BR, 0, 0, 1, 32'h80, 8'h41, ck(0, 0));
    tbl[5]  = fx(1, 32'h200, JAL, 1, 0, 0, 32'h204, 8'h81, ck(1, 1));
    tbl[6]  = fx(1, 32'h300, JALR, 0, 1, 1, 32'h204, 8'hC1, ck(0, 0));
    tbl[7]  = fx(1, 32'h400, NOP, 0, 0, 0, 32'h404, 8'h01, ck(0, 0));
    tbl[8]  = rx(fx(1, 32'h100, BR, 0, 0, 1, 32'h80, 8'h41, ck(0, 0)),
                 32'h100, BR, 8'h48, 0, 32'h0, 0, ck(0, 0));
    tbl[9]  = rx(fx(0, 32'h600, NOP, 0, 0, 0, 32'h604, 8'h82, ck(0, 0)),
                 32'h100, BR, 8'h48, 0, 32'h0, 0, ck(0, 0));
    tbl[10] = rx(fx(0, 32'h600, NOP, 0, 0, 0, 32'h604, 8'h84, ck(0, 0)),
                 32'h100, BR, 8'h48, 0, 32'h0, 0, ck(0, 0));
    // counter at 00 after three not-taken: BTB hit but predicted not taken
    tbl[11] = fx(1, 32'h100, BR, 0, 0, 0, 32'h104, 8'h48, ck(0, 0));
    tbl[12] = fx(0, 32'h600, NOP, 0, 0, 0, 32'h604, 8'h88, ck(0, 0));

    run(rstv(), "rst");
    for (int i = 0; i < 13; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // RAS overflow: 9 calls wrap the 8-entry stack, slot 1 now holds 0x1024
    run(rstv(), "rst");
    for (int k = 0; k < 9; k++)
      run(fx(1, 32'h1000 + 32'(4*k), JAL, 1, 0, 0, 32'h1004 + 32'(4*k), 8'(k),
             ck((k + 1) & 7, (k + 1 > 8) ? 8 : k + 1)), $sformatf("call%0d", k));
    for (int j = 0; j < 8; j++)
      run(fx(1, 32'h2000 + 32'(4*j), JALR, 0, 1, 1, 32'h1024 - 32'(4*j), 8'(j),
             ck((-j) & 7, 7 - j)), $sformatf("ret%0d", j));
    run(fx(1, 32'h2020, JALR, 0, 1, 0, 32'h2024, 8'h08, ck(1, 0)), "ret_empty");

    // same-set LRU eviction: 0x40, 0x80, 0xC0 all map to set 0
    run(rstv(), "rst");
    run(rx(quiet(32'h700), 32'h40, BR, 8'h10, 1, 32'h900, 1, ck(0, 0)), "trainA");
    run(rx(quiet(32'h700), 32'h80, BR, 8'h21, 1, 32'hA00, 1, ck(0, 0)), "trainB");
    run(fx(1, 32'h40, BR, 0, 0, 1, 32'h900, 8'h13, ck(0, 0)), "hitA");
    run(rx(quiet(32'h700), 32'hC0, BR, 8'h33, 1, 32'hB00, 1, ck(0, 0)), "trainC");
    run(fx(1, 32'h40, BR, 0, 0, 0, 32'h44, 8'h17, ck(0, 0)), "evictedA");
    run(fx(1, 32'h80, BR, 0, 0, 1, 32'hA00, 8'h27, ck(0, 0)), "keptB");
    run(fx(1, 32'hC0, BR, 0, 0, 1, 32'hB00, 8'h37, ck(0, 0)), "newC");

    // checkpoint restore beats a same-cycle fetch pop
    run(rstv(), "rst");
    run(fx(1, 32'h1000, JAL, 1, 0, 0, 32'h1004, 8'h00, ck(1, 1)), "rs_call");
    run(rx(fx(1, 32'h2000, JALR, 0, 1, 1, 32'h1004, 8'h00, ck(0, 0)),
           32'h3000, BR, 8'h00, 0, 32'h0, 1, ck(3, 3)), "rs_ret_flush");
    run(fx(0, 32'h3000, NOP, 0, 0, 0, 32'h3004, 8'h00, ck(3, 3)), "rs_restored");
    begin
      vec_t v;
      v = fx(1, 32'h2004, JALR, 0, 1, 1, 32'h0, 8'h01, ck(2, 2));
      v.chk_tgt = 1'b0;
      run(v, "rs_pop");
      // reset mid-operation drops the same-cycle resolve and the fetch call
      v = rx(fx(1, 32'h1000, JAL, 1, 0, 0, 32'h0, 8'h0, ck(0, 0)),
             32'h100, BR, 8'h40, 1, 32'h80, 0, ck(0, 0));
      v.rst = 1'b1;
      v.chk = 1'b0;
      run(v, "mid_rst");
    end
    run(fx(0, 32'h3000, NOP, 0, 0, 0, 32'h3004, 8'h00, ck(0, 0)), "post_rst_ras");
    run(fx(1, 32'h100, BR, 0, 0, 0, 32'h104, 8'h40, ck(0, 0)), "post_rst_btb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
